rd_burst_ctrl: RTL and testbench



---
 rtl/rd_burst_ctrl.sv | 117 +++++++++++
 tb/tb_rd_burst_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_ctrl.sv
// Read-side burst sequencer for an async FIFO: waits for N words to be visible,
// pops them with rinc and presents them on a registered valid/ready stream with a last marker.
module rd_burst_ctrl #(
  parameter int ADDR_SIZE      = 4,
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty,
  input  logic [ADDR_SIZE:0]   rptr,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE:0]   req_len,
  output logic                 req_ready,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [ADDR_SIZE:0]   level,
  output logic                 short_burst
);
  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_SIZE);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

  state_t          state;
  logic [PW-1:0]   len;
  logic [PW-1:0]   remaining;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   len_clamped;
  logic            pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Lagging write pointer makes this a lower bound on true occupancy.
  always_comb begin
    level = gray2bin(rq2_wptr) - gray2bin(rptr);
  end

  always_comb begin
    len_clamped = req_len;
    if (req_len == '0)
      len_clamped = PW'(1);
    else if (req_len > DEPTH)
      len_clamped = DEPTH;
  end

  // rempty guards against popping on a stale level.
  assign pop       = (state == S_STREAM) && (remaining != '0) && !rempty &&
                     (!out_valid || out_ready);
  assign rinc      = pop;
  assign req_ready = rrst_n && (state == S_IDLE);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      remaining   <= '0;
      timer       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      short_burst <= 1'b0;
    end else begin
      short_burst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            len       <= len_clamped;
            remaining <= len_clamped;
            timer     <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (level >= len) begin
            state <= S_STREAM;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (timer != TLAST) begin
              timer <= timer + 1'b1;
            end else if (level != '0) begin
              len         <= level;
              remaining   <= level;
              short_burst <= 1'b1;
              state       <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (pop) begin
            out_data  <= rdata;
            out_valid <= 1'b1;
            out_last  <= (remaining == PW'(1));
            remaining <= remaining - 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Bench for rd_burst_ctrl: behavioural FIFO around the DUT, word-order scoreboard,
// and protocol monitors for stalls, empty pops and timeout pulses.
`timescale 1ns/1ps
module tb_rd_burst_ctrl;
  localparam int A = 4, D = 8, TO = 16, PW = A + 1, DEPTH = 16;

  logic          rclk = 1'b0, rrst_n = 1'b1;
  logic          rempty, rinc, req_ready, out_valid, out_last, short_burst;
  logic          req_valid = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] rptr, rq2_wptr, level, req_len = '0;
  logic [D-1:0]  rdata, out_data;

  always #5 rclk = ~rclk;

  rd_burst_ctrl #(.ADDR_SIZE(A), .DATA_SIZE(D), .TIMEOUT_CYCLES(TO)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rptr(rptr), .rq2_wptr(rq2_wptr),
    .rdata(rdata), .rinc(rinc), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .level(level), .short_burst(short_burst)
  );

  // Behavioural FIFO: binary pointers, two-stage write pointer synchronizer.
  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] wbin = '0, rbin, ws1, ws2;
  logic [D-1:0]  fifo_q[$];

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign rptr     = b2g(rbin);
  assign rq2_wptr = b2g(ws2);
  assign rdata    = mem[rbin[A-1:0]];
  assign rempty   = (rbin == ws2);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin <= '0; ws1 <= '0; ws2 <= '0;
    end else begin
      ws1 <= wbin; ws2 <= ws1;
      if (rinc) rbin <= rbin + 1'b1;
    end
  end

  // Monitor sampled on the falling edge.
  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  logic [D:0] obs_q[$];
  int rinc_cnt, empty_pop_err, stall_err, short_cnt, last_cnt;
  int hs_last_cyc, first_rinc_cyc, last_rinc_cyc, level_first_rinc;
  logic prev_stall = 1'b0, prev_last;
  logic [D-1:0] prev_data;

  always @(negedge rclk) begin
    if (rrst_n) begin
      if (out_valid && out_ready) begin
        obs_q.push_back({out_last, out_data});
        if (out_last) begin last_cnt++; hs_last_cyc = cyc; end
      end
      if (rinc) begin
        if (rinc_cnt == 0) begin first_rinc_cyc = cyc; level_first_rinc = int'(level); end
        last_rinc_cyc = cyc;
        rinc_cnt++;
        if (rempty) empty_pop_err++;
        if (out_valid && !out_ready) stall_err++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      if (short_burst) short_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int n_pass = 0, n_total = 0, acc_cyc = 0;

  task automatic tick();
    @(posedge rclk); #1;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    rinc_cnt = 0; empty_pop_err = 0; stall_err = 0; short_cnt = 0; last_cnt = 0;
    hs_last_cyc = 0; first_rinc_cyc = 0; last_rinc_cyc = 0; level_first_rinc = -1;
  endtask

  task automatic write_word(input logic [D-1:0] d);
    mem[wbin[A-1:0]] = d;
    wbin = wbin + 1'b1;
    fifo_q.push_back(d);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    wbin = '0; fifo_q.delete();
    repeat (2) tick();
    rrst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic issue(input int len, output bit ok);
    int n = 0;
    req_len = PW'(len); req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    ok = (req_ready === 1'b1);
    tick();
    req_valid = 1'b0; acc_cyc = cyc;
  endtask

  // mode 0: ready held high, 1: 1,0,0 repeating, 2: random
  task automatic wait_last(input int mode, input int budget, output bit ok);
    int target = last_cnt + 1;
    int n = 0;
    while (last_cnt < target && n < budget) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick(); n++;
    end
    ok = (last_cnt >= target);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b want 0", out_last); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %0h want 0", out_data); else n_pass++;
    n_total++; if (short_burst !== 1'b0) $display("FAIL reset_short_burst got %0b want 0", short_burst); else n_pass++;
    n_total++; if (rinc !== 1'b0) $display("FAIL reset_rinc got %0b want 0", rinc); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", req_ready); else n_pass++;
    repeat (2) tick();
    rrst_n = 1'b1; tick();
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", req_ready); else n_pass++;
    n_total++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    clear_mon();
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    logic [D:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'h10 + D'(i));
    repeat (3) tick();
    n_total++; if (level !== 5'd8) $display("FAIL basic_level_pre got %0d want 8", level); else n_pass++;
    issue(4, ok1);
    wait_last(0, 50, ok2);
    n_total++; if (!(ok1 && ok2)) $display("FAIL basic_timeout got accept=%0b last=%0b want 1 1", ok1, ok2); else n_pass++;
    n_total++; if (rinc_cnt != 4 || last_rinc_cyc - first_rinc_cyc != 3)
      $display("FAIL basic_rinc_run got count=%0d span=%0d want 4 3", rinc_cnt, last_rinc_cyc - first_rinc_cyc); else n_pass++;
    n_total++; if (req_ready !== 1'b1 || cyc - hs_last_cyc != 1)
      $display("FAIL basic_ready_return got ready=%0b gap=%0d want 1 1", req_ready, cyc - hs_last_cyc); else n_pass++;
    n_total++; if (level !== 5'd4) $display("FAIL basic_level_post got %0d want 4", level); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      want = {(i == 3), fifo_q.pop_front()};
      n_total++;
      if (i >= obs_q.size() || obs_q[i] !== want)
        $display("FAIL basic_word%0d got %0h want %0h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
      else n_pass++;
    end
  endtask

  task automatic test_trickle();
    bit ok1, ok2;
    logic [D:0] want;
    do_reset();
    fork
      issue(3, ok1);
      begin
        for (int i = 0; i < 3; i++) begin
          write_word(8'h40 + D'(i));
          repeat (5) tick();
        end
      end
    join
    wait_last(0, 60, ok2);
    n_total++; if (!(ok1 && ok2)) $display("FAIL trickle_timeout got accept=%0b last=%0b want 1 1", ok1, ok2); else n_pass++;
    n_total++; if (level_first_rinc != 3) $display("FAIL trickle_first_pop_level got %0d want 3", level_first_rinc); else n_pass++;
    n_total++; if (rinc_cnt != 3 || short_cnt != 0 || empty_pop_err != 0)
      $display("FAIL trickle_pops got rinc=%0d short=%0d emptypop=%0d want 3 0 0", rinc_cnt, short_cnt, empty_pop_err); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      want = {(i == 2), fifo_q.pop_front()};
      n_total++;
      if (i >= obs_q.size() || obs_q[i] !== want)
        $display("FAIL trickle_word%0d got %0h want %0h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok1, ok2;
    int k = 0;
    logic [D:0] want;
    do_reset();
    write_word(8'hA1); write_word(8'hB2);
    repeat (3) tick();
    issue(5, ok1);
    while (short_burst !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++; if (k != TO) $display("FAIL timeout_wait_cycles got %0d want %0d", k, TO); else n_pass++;
    wait_last(0, 50, ok2);
    repeat (3) tick();
    n_total++; if (!(ok1 && ok2)) $display("FAIL timeout_done got accept=%0b last=%0b want 1 1", ok1, ok2); else n_pass++;
    n_total++; if (short_cnt != 1) $display("FAIL timeout_pulse_count got %0d want 1", short_cnt); else n_pass++;
    n_total++; if (rinc_cnt != 2 || obs_q.size() != 2 || req_ready !== 1'b1)
      $display("FAIL timeout_len got rinc=%0d words=%0d ready=%0b want 2 2 1", rinc_cnt, obs_q.size(), req_ready); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      want = {(i == 1), fifo_q.pop_front()};
      n_total++;
      if (i >= obs_q.size() || obs_q[i] !== want)
        $display("FAIL timeout_word%0d got %0h want %0h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    logic [D:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) write_word(D'($urandom));
    repeat (3) tick();
    issue(6, ok1);
    wait_last(1, 100, ok2);
    n_total++; if (!(ok1 && ok2)) $display("FAIL bp_done got accept=%0b last=%0b want 1 1", ok1, ok2); else n_pass++;
    n_total++; if (stall_err != 0 || empty_pop_err != 0)
      $display("FAIL bp_stall got stallerr=%0d emptypop=%0d want 0 0", stall_err, empty_pop_err); else n_pass++;
    n_total++; if (rinc_cnt != 6 || obs_q.size() != 6)
      $display("FAIL bp_count got rinc=%0d words=%0d want 6 6", rinc_cnt, obs_q.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      want = {(i == 5), fifo_q.pop_front()};
      n_total++;
      if (i >= obs_q.size() || obs_q[i] !== want)
        $display("FAIL bp_word%0d got %0h want %0h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2, ok3, ok4;
    logic [D:0] want;
    do_reset();
    for (int i = 0; i < 14; i++) write_word(D'($urandom));
    repeat (3) tick();
    issue(14, ok1);
    wait_last(0, 80, ok2);
    for (int i = 0; i < 14; i++) void'(fifo_q.pop_front());
    clear_mon();
    for (int i = 0; i < 4; i++) write_word(8'hC0 + D'(i));
    repeat (3) tick();
    n_total++; if (level !== 5'd4) $display("FAIL wrap_level got %0d want 4", level); else n_pass++;
    issue(4, ok3);
    wait_last(0, 50, ok4);
    n_total++; if (!(ok1 && ok2 && ok3 && ok4)) $display("FAIL wrap_done got %0b%0b%0b%0b want 1111", ok1, ok2, ok3, ok4); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      want = {(i == 3), fifo_q.pop_front()};
      n_total++;
      if (i >= obs_q.size() || obs_q[i] !== want)
        $display("FAIL wrap_word%0d got %0h want %0h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok1;
    int k = 0;
    do_reset();
    for (int i = 0; i < 5; i++) write_word(8'h60 + D'(i));
    repeat (3) tick();
    issue(5, ok1);
    out_ready = 1'b1;
    while (obs_q.size() < 2 && k < 30) begin tick(); k++; end
    n_total++; if (!ok1 || obs_q.size() != 2) $display("FAIL rstmid_progress got accept=%0b words=%0d want 1 2", ok1, obs_q.size()); else n_pass++;
    rrst_n = 1'b0; #1;
    n_total++; if (out_valid !== 1'b0 || rinc !== 1'b0 || req_ready !== 1'b0 || out_last !== 1'b0)
      $display("FAIL rstmid_outputs got valid=%0b rinc=%0b ready=%0b last=%0b want 0 0 0 0", out_valid, rinc, req_ready, out_last); else n_pass++;
    wbin = '0; fifo_q.delete();
    repeat (2) tick();
    rrst_n = 1'b1; tick();
    n_total++; if (req_ready !== 1'b1 || level !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL rstmid_release got ready=%0b level=%0d valid=%0b want 1 0 0", req_ready, level, out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok1, ok2;
    int len, n;
    logic [D:0] want;
    do_reset();
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(0, 20);
      n = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
      while (fifo_q.size() < n) write_word(D'($urandom));
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < DEPTH) write_word(D'($urandom));
      repeat (3) tick();
      clear_mon();
      issue(len, ok1);
      wait_last(2, 400, ok2);
      n_total++; if (!(ok1 && ok2) || short_cnt != 0 || stall_err != 0 || obs_q.size() != n)
        $display("FAIL rand%0d_burst len=%0d got words=%0d short=%0d stallerr=%0d want %0d 0 0", b, len, obs_q.size(), short_cnt, stall_err, n);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
        want = {(i == n - 1), fifo_q.pop_front()};
        n_total++;
        if (i >= obs_q.size() || obs_q[i] !== want)
          $display("FAIL rand%0d_word%0d got %0h want %0h", b, i, (i < obs_q.size()) ? obs_q[i] : 9'h1ff, want);
        else n_pass++;
      end
    end
  endtask

  initial begin
    clear_mon();
    #2;
    test_reset();
    test_basic();
    test_trickle();
    test_timeout();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
